tdc_event_packer: RTL and testbench

//  Consumes per-channel hit timestamps (coarse count + fine TDL code) from the TDC front-end and packs them into

---
 rtl/tdc_pkg.sv | 25 ++
 rtl/tdc_rr_arb.sv | 39 +++
 rtl/tdc_event_packer.sv | 162 ++++++++++++++++
 tb/tb_tdc_event_packer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared word-type codes, default field widths and drop-counter helpers for the TDC event packer.
package tdc_pkg;

  localparam int TYPE_W = 2;
  localparam logic [TYPE_W-1:0] TYPE_HDR  = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_STOP = 2'b10;

  localparam int DEF_CHANNEL    = 3;
  localparam int DEF_COARSE_W   = 20;
  localparam int DEF_FINE_W     = 8;
  localparam int DEF_CH_W       = 2;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Saturating add so the drop counter sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [DROP_W-1:0] b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DROP_W] ? DROP_MAX : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/tdc_rr_arb.sv
// Round-robin arbiter over the STOP channels; ptr/next_ptr are channel numbers (1..NREQ, 0 means start at 1).
module tdc_rr_arb #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_any,
  output logic [PTR_W-1:0] next_ptr
);

  int base;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    next_ptr = ptr;
    base     = (ptr == '0) ? 0 : int'(ptr) - 1;
    if (base >= NREQ) base = 0;
    // Search from the pointer upward, then wrap to the low requests.
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && j >= base && req[j]) begin
        gnt[j]   = 1'b1;
        gnt_any  = 1'b1;
        next_ptr = (j == NREQ - 1) ? PTR_W'(1) : PTR_W'(j + 2);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && j < base && req[j]) begin
        gnt[j]   = 1'b1;
        gnt_any  = 1'b1;
        next_ptr = (j == NREQ - 1) ? PTR_W'(1) : PTR_W'(j + 2);
      end
    end
  end

endmodule

// File: rtl/tdc_event_packer.sv
// Packs START headers and STOP coarse deltas into output words; a 1-bit epoch keeps STOPs behind their header.
module tdc_event_packer
  import tdc_pkg::*;
#(
  parameter int CHANNEL    = DEF_CHANNEL,
  parameter int COARSE_W   = DEF_COARSE_W,
  parameter int FINE_W     = DEF_FINE_W,
  parameter int CH_W       = DEF_CH_W,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [CHANNEL-1:0]           hit_vld,
  input  logic [CHANNEL*COARSE_W-1:0]  hit_coarse,
  input  logic [CHANNEL*FINE_W-1:0]    hit_fine,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [DROP_W-1:0]            drop_cnt,
  output logic                         start_seen
);

  localparam int NSTOP = CHANNEL - 1;
  localparam int PTR_W = (CHANNEL > 2) ? $clog2(CHANNEL) : 1;

  if (TYPE_W + CH_W + COARSE_W + FINE_W != DATA_WIDTH) begin : g_width_check
    $error("tdc_event_packer: TYPE_W+CH_W+COARSE_W+FINE_W must equal DATA_WIDTH");
  end

  logic [COARSE_W-1:0] start_coarse;
  logic [FINE_W-1:0]   start_fine;
  logic                hdr_pend;
  logic                in_epoch;
  logic                out_epoch;
  logic [NSTOP-1:0]    pend;
  logic [NSTOP-1:0]    epoch;
  logic [COARSE_W-1:0] delta_q [NSTOP];
  logic [FINE_W-1:0]   fine_q  [NSTOP];
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;

  logic                  out_free;
  logic                  stop_gnt_any;
  logic                  hdr_gnt;
  logic                  start_take;
  logic [NSTOP-1:0]      eligible;
  logic [NSTOP-1:0]      arb_req;
  logic [NSTOP-1:0]      gnt;
  logic [NSTOP-1:0]      stop_take;
  logic [DROP_W-1:0]     drop_inc;
  logic [DATA_WIDTH-1:0] stop_word;
  logic [DATA_WIDTH-1:0] hdr_word;

  assign out_free = !out_vld || out_rdy;

  always_comb begin
    for (int i = 0; i < NSTOP; i++) eligible[i] = pend[i] && (epoch[i] == out_epoch);
  end

  assign arb_req = out_free ? eligible : '0;

  tdc_rr_arb #(
    .NREQ  (NSTOP),
    .PTR_W (PTR_W)
  ) u_arb (
    .req      (arb_req),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .gnt_any  (stop_gnt_any),
    .next_ptr (rr_next)
  );

  // Header only goes out when no STOP of the current epoch is waiting.
  assign hdr_gnt    = out_free && !stop_gnt_any && hdr_pend;
  assign start_take = hit_vld[0] && (!hdr_pend || hdr_gnt);

  always_comb begin
    stop_take = '0;
    drop_inc  = '0;
    if (hit_vld[0] && !start_take) drop_inc = drop_inc + DROP_W'(1);
    for (int i = 0; i < NSTOP; i++) begin
      if (hit_vld[i+1]) begin
        if (start_seen && (!pend[i] || gnt[i])) stop_take[i] = 1'b1;
        else drop_inc = drop_inc + DROP_W'(1);
      end
    end
  end

  always_comb begin
    stop_word = '0;
    for (int i = 0; i < NSTOP; i++) begin
      if (gnt[i]) stop_word = {TYPE_STOP, CH_W'(i + 1), delta_q[i], fine_q[i]};
    end
  end

  assign hdr_word = {TYPE_HDR, {CH_W{1'b0}}, start_coarse, start_fine};

  // NOTE: non-blocking updates mean a same-cycle STOP sees the previous start regs and in_epoch.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start_coarse <= '0;
      start_fine   <= '0;
      hdr_pend     <= 1'b0;
      in_epoch     <= 1'b0;
      out_epoch    <= 1'b0;
      start_seen   <= 1'b0;
      pend         <= '0;
      epoch        <= '0;
      rr_ptr       <= '0;
      out_data     <= '0;
      out_vld      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      drop_cnt <= sat_add(drop_cnt, drop_inc);

      if (start_take) begin
        start_coarse <= hit_coarse[COARSE_W-1:0];
        start_fine   <= hit_fine[FINE_W-1:0];
        in_epoch     <= !in_epoch;
        start_seen   <= 1'b1;
        hdr_pend     <= 1'b1;
      end else if (hdr_gnt) begin
        hdr_pend <= 1'b0;
      end
      if (hdr_gnt) out_epoch <= !out_epoch;

      for (int i = 0; i < NSTOP; i++) begin
        if (stop_take[i]) begin
          pend[i]  <= 1'b1;
          epoch[i] <= in_epoch;
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end

      if (out_free) begin
        if (stop_gnt_any) begin
          out_data <= stop_word;
          out_vld  <= 1'b1;
        end else if (hdr_gnt) begin
          out_data <= hdr_word;
          out_vld  <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end

      if (stop_gnt_any) rr_ptr <= rr_next;
    end
  end

  // NOTE: payload regs carry no reset; they are only read while their pend flag is set.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NSTOP; i++) begin
      if (stop_take[i]) begin
        delta_q[i] <= hit_coarse[(i+1)*COARSE_W +: COARSE_W] - start_coarse;
        fine_q[i]  <= hit_fine[(i+1)*FINE_W +: FINE_W];
      end
    end
  end

endmodule

// File: tb/tb_tdc_event_packer.sv
// Directed scoreboard bench for tdc_event_packer: expected words queued at stimulus, checked at handshake.
module tb_tdc_event_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  hit_vld;
  logic [59:0] hit_coarse;
  logic [23:0] hit_fine;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] drop_cnt;
  logic        start_seen;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  tdc_event_packer dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .hit_vld    (hit_vld),
    .hit_coarse (hit_coarse),
    .hit_fine   (hit_fine),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .drop_cnt   (drop_cnt),
    .start_seen (start_seen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr_w(input logic [19:0] c, input logic [7:0] f);
    return {2'b01, 2'b00, c, f};
  endfunction

  function automatic logic [31:0] stop_w(input int ch, input logic [19:0] d, input logic [7:0] f);
    return {2'b10, 2'(ch), d, f};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] v,
                       input logic [19:0] c0, input logic [19:0] c1, input logic [19:0] c2,
                       input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2);
    hit_vld    = v;
    hit_coarse = {c2, c1, c0};
    hit_fine   = {f2, f1, f0};
    step();
    hit_vld = 3'b000;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: a word is consumed on the edge following a negedge with out_vld & out_rdy.
  always @(negedge sys_clk) begin
    if (!sys_rst && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_word: observed %h expected none", out_data);
        end
      end else begin
        check("word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sys_rst    = 1'b1;
    out_rdy    = 1'b1;
    hit_vld    = 3'b000;
    hit_coarse = '0;
    hit_fine   = '0;
    repeat (3) step();
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_start_seen", 32'(start_seen), 32'd0);
    sys_rst = 1'b0;
    step();

    // STOP before any START is dropped.
    pulse(3'b010, 20'd0, 20'd50, 20'd0, 8'd0, 8'd1, 8'd0);
    check("t1_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t1_start_seen", 32'(start_seen), 32'd0);
    repeat (3) step();
    check("t1_no_output", 32'(out_vld), 32'd0);

    // First START then a STOP; header appears two edges after the START hit.
    exp_q.push_back(32'h4000_6407);
    exp_q.push_back(32'h9000_FA03);
    pulse(3'b001, 20'd100, 20'd0, 20'd0, 8'd7, 8'd0, 8'd0);
    check("t2_not_early", 32'(out_vld), 32'd0);
    check("t2_start_seen", 32'(start_seen), 32'd1);
    pulse(3'b010, 20'd0, 20'd350, 20'd0, 8'd0, 8'd3, 8'd0);
    check("t2_latency_vld", 32'(out_vld), 32'd1);
    check("t2_latency_data", out_data, 32'h4000_6407);
    drain();

    // Coarse delta wraps modulo 2^20.
    exp_q.push_back(hdr_w(20'hFFFF0, 8'h11));
    exp_q.push_back(32'hA000_2022);
    pulse(3'b001, 20'hFFFF0, 20'd0, 20'd0, 8'h11, 8'd0, 8'd0);
    pulse(3'b100, 20'd0, 20'd0, 20'h00010, 8'd0, 8'd0, 8'h22);
    drain();

    // Same-cycle START+STOP: the STOP belongs to the old frame and leaves first.
    exp_q.push_back(hdr_w(20'd400, 8'h10));
    pulse(3'b001, 20'd400, 20'd0, 20'd0, 8'h10, 8'd0, 8'd0);
    drain();
    exp_q.push_back(stop_w(1, 20'd120, 8'd5));
    exp_q.push_back(hdr_w(20'd500, 8'd9));
    exp_q.push_back(stop_w(1, 20'd30, 8'd6));
    pulse(3'b011, 20'd500, 20'd520, 20'd0, 8'd9, 8'd5, 8'd0);
    pulse(3'b010, 20'd0, 20'd530, 20'd0, 8'd0, 8'd6, 8'd0);
    drain();
    exp_q.push_back(stop_w(2, 20'd40, 8'h0c));
    pulse(3'b100, 20'd0, 20'd0, 20'd540, 8'd0, 8'd0, 8'h0c);
    drain();
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);

    // Backpressure: held word stays put, repeat hits drop, release drains in RR order.
    out_rdy = 1'b0;
    exp_q.push_back(stop_w(2, 20'd60, 8'h21));
    exp_q.push_back(stop_w(1, 20'd100, 8'h31));
    exp_q.push_back(stop_w(2, 20'd150, 8'h32));
    exp_q.push_back(hdr_w(20'd700, 8'h44));
    pulse(3'b100, 20'd0, 20'd0, 20'd560, 8'd0, 8'd0, 8'h21);
    step();
    pulse(3'b110, 20'd0, 20'd600, 20'd650, 8'd0, 8'h31, 8'h32);
    pulse(3'b001, 20'd700, 20'd0, 20'd0, 8'h44, 8'd0, 8'd0);
    pulse(3'b011, 20'd720, 20'd610, 20'd0, 8'h55, 8'h66, 8'd0);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd3);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_vld", 32'(out_vld), 32'd1);
      check("t5_hold_data", out_data, stop_w(2, 20'd60, 8'h21));
      step();
    end
    out_rdy = 1'b1;
    drain();
    check("t5_drop_after", 32'(drop_cnt), 32'd3);

    // Reset mid-transfer discards pending and output state.
    out_rdy = 1'b0;
    pulse(3'b001, 20'd800, 20'd0, 20'd0, 8'h01, 8'd0, 8'd0);
    pulse(3'b010, 20'd0, 20'd810, 20'd0, 8'd0, 8'h02, 8'd0);
    pulse(3'b100, 20'd0, 20'd0, 20'd820, 8'd0, 8'd0, 8'h03);
    check("t6_pre_vld", 32'(out_vld), 32'd1);
    sys_rst = 1'b1;
    step();
    check("t6_rst_vld", 32'(out_vld), 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    check("t6_rst_seen", 32'(start_seen), 32'd0);
    sys_rst = 1'b0;
    out_rdy = 1'b1;
    repeat (10) step();
    check("t6_no_stale", 32'(out_vld), 32'd0);

    // STOP in the same cycle as the first START after reset is dropped.
    exp_q.push_back(hdr_w(20'd5, 8'h0a));
    pulse(3'b011, 20'd5, 20'd6, 20'd0, 8'h0a, 8'h01, 8'd0);
    check("t7_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t7_start_seen", 32'(start_seen), 32'd1);
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
